// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic-light command path: command codes, framer states, payload.
package traffic_lights_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned CMD_TYPE_W = 3;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned CNT_W      = 16;

   typedef enum logic [CMD_TYPE_W-1:0] {
      CMD_TURN_ON         = 3'd0,
      CMD_TURN_OFF        = 3'd1,
      CMD_SET_UNCONTR     = 3'd2,
      CMD_SET_GREEN_TIME  = 3'd3,
      CMD_SET_RED_TIME    = 3'd4,
      CMD_SET_YELLOW_TIME = 3'd5
   } cmd_code_e;

   // Highest legal command code, widened to a full link byte for comparison.
   localparam logic [BYTE_W-1:0] MAX_CMD_CODE = BYTE_W'(CMD_SET_YELLOW_TIME);

   typedef enum logic [2:0] {
      ST_HUNT = 3'd0,
      ST_TYPE = 3'd1,
      ST_DHI  = 3'd2,
      ST_DLO  = 3'd3,
      ST_CSUM = 3'd4,
      ST_EMIT = 3'd5
   } framer_state_e;

   typedef struct packed {
      logic [CMD_TYPE_W-1:0] cmd_type;
      logic [DATA_W-1:0]     data;
   } cmd_payload_t;

   // Frame checksum: XOR of the three body bytes.
   function automatic logic [BYTE_W-1:0] frame_csum(input logic [BYTE_W-1:0] t,
                                                    input logic [BYTE_W-1:0] hi,
                                                    input logic [BYTE_W-1:0] lo);
      return t ^ hi ^ lo;
   endfunction

endpackage

// File: rtl/traffic_cmd_timer.sv
// Inter-byte idle timer: counts idle cycles inside a frame, flags expiry combinationally.
module traffic_cmd_timer
   import traffic_lights_pkg::*;
#(
   parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd1000
) (
   input  logic clk,
   input  logic srst_n,
   input  logic clear,
   input  logic enable,
   output logic expire_c
);

   logic [CNT_W-1:0] count;

   // Idle counter; saturates so it can never wrap back under the limit.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   // Expiry is seen in the idle cycle that would bring the count up to the limit.
   assign expire_c = enable && (count >= (TIMEOUT_CYCLES - CNT_W'(1)));

endmodule

// File: rtl/traffic_cmd_framer.sv
// Byte-stream framer: finds SYNC-led 5-byte frames, validates them and emits traffic_lights commands.
module traffic_cmd_framer
   import traffic_lights_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_BYTE      = 8'hA5,
   parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 16'd1000
) (
   input  logic                  clk_i,
   input  logic                  srst_n_i,
   input  logic [BYTE_W-1:0]     byte_data_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic [CMD_TYPE_W-1:0] cmd_type_o,
   output logic [DATA_W-1:0]     cmd_data_o,
   output logic                  cmd_valid_o,
   output logic                  err_csum_o,
   output logic                  err_type_o,
   output logic                  err_timeout_o,
   output logic [CNT_W-1:0]      frames_ok_o
);

   framer_state_e     state_q, state_d;
   logic [BYTE_W-1:0] type_q, type_d;
   logic [BYTE_W-1:0] dhi_q, dhi_d;
   logic [BYTE_W-1:0] dlo_q, dlo_d;
   cmd_payload_t      cmd_q, cmd_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              err_csum_q, err_csum_d;
   logic              err_type_q, err_type_d;
   logic              err_timeout_q, err_timeout_d;
   logic              ready_q, ready_d;
   logic [CNT_W-1:0]  frames_q, frames_d;

   logic xfer_c;
   logic timer_clear_c;
   logic expire_c;

   assign xfer_c        = byte_valid_i && ready_q;
   assign timer_clear_c = xfer_c || (state_q == ST_HUNT) || (state_q == ST_EMIT);

   traffic_cmd_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk_i),
      .srst_n   (srst_n_i),
      .clear    (timer_clear_c),
      .enable   (!timer_clear_c),
      .expire_c (expire_c)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q <= ST_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, byte capture and next values of the registered outputs.
   always_comb begin
      state_d       = state_q;
      type_d        = type_q;
      dhi_d         = dhi_q;
      dlo_d         = dlo_q;
      cmd_d         = '0;
      cmd_valid_d   = 1'b0;
      err_csum_d    = 1'b0;
      err_type_d    = 1'b0;
      err_timeout_d = 1'b0;
      frames_d      = frames_q;

      case (state_q)
         ST_HUNT: begin
            if (xfer_c && (byte_data_i == SYNC_BYTE)) begin
               state_d = ST_TYPE;
            end
         end
         ST_TYPE: begin
            if (xfer_c) begin
               type_d  = byte_data_i;
               state_d = ST_DHI;
            end else if (expire_c) begin
               err_timeout_d = 1'b1;
               state_d       = ST_HUNT;
            end
         end
         ST_DHI: begin
            if (xfer_c) begin
               dhi_d   = byte_data_i;
               state_d = ST_DLO;
            end else if (expire_c) begin
               err_timeout_d = 1'b1;
               state_d       = ST_HUNT;
            end
         end
         ST_DLO: begin
            if (xfer_c) begin
               dlo_d   = byte_data_i;
               state_d = ST_CSUM;
            end else if (expire_c) begin
               err_timeout_d = 1'b1;
               state_d       = ST_HUNT;
            end
         end
         ST_CSUM: begin
            if (xfer_c) begin
               if (byte_data_i != frame_csum(type_q, dhi_q, dlo_q)) begin
                  err_csum_d = 1'b1;
                  state_d    = ST_HUNT;
               end else if (type_q > MAX_CMD_CODE) begin
                  err_type_d = 1'b1;
                  state_d    = ST_HUNT;
               end else begin
                  state_d        = ST_EMIT;
                  cmd_valid_d    = 1'b1;
                  cmd_d.cmd_type = type_q[CMD_TYPE_W-1:0];
                  cmd_d.data     = {dhi_q, dlo_q};
                  if (frames_q != '1) begin
                     frames_d = frames_q + CNT_W'(1);
                  end
               end
            end else if (expire_c) begin
               err_timeout_d = 1'b1;
               state_d       = ST_HUNT;
            end
         end
         ST_EMIT: begin
            state_d = ST_HUNT;
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase

      ready_d = (state_d != ST_EMIT);
   end

   // Captured frame bytes and registered outputs.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         type_q        <= '0;
         dhi_q         <= '0;
         dlo_q         <= '0;
         cmd_q         <= '0;
         cmd_valid_q   <= 1'b0;
         err_csum_q    <= 1'b0;
         err_type_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         ready_q       <= 1'b1;
         frames_q      <= '0;
      end else begin
         type_q        <= type_d;
         dhi_q         <= dhi_d;
         dlo_q         <= dlo_d;
         cmd_q         <= cmd_d;
         cmd_valid_q   <= cmd_valid_d;
         err_csum_q    <= err_csum_d;
         err_type_q    <= err_type_d;
         err_timeout_q <= err_timeout_d;
         ready_q       <= ready_d;
         frames_q      <= frames_d;
      end
   end

   assign byte_ready_o  = ready_q;
   assign cmd_type_o    = cmd_q.cmd_type;
   assign cmd_data_o    = cmd_q.data;
   assign cmd_valid_o   = cmd_valid_q;
   assign err_csum_o    = err_csum_q;
   assign err_type_o    = err_type_q;
   assign err_timeout_o = err_timeout_q;
   assign frames_ok_o   = frames_q;

endmodule

// File: tb/tb_traffic_cmd_framer.sv
// Scoreboard bench for traffic_cmd_framer: frame-level reference model, event queue, negedge monitor.
module tb_traffic_cmd_framer;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TMO  = 1000;

   logic        clk_i = 1'b0;
   logic        srst_n_i = 1'b0;
   logic [7:0]  byte_data_i = 8'h00;
   logic        byte_valid_i = 1'b0;
   logic        byte_ready_o;
   logic [2:0]  cmd_type_o;
   logic [15:0] cmd_data_o;
   logic        cmd_valid_o;
   logic        err_csum_o;
   logic        err_type_o;
   logic        err_timeout_o;
   logic [15:0] frames_ok_o;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   always #5 clk_i = ~clk_i;

   traffic_cmd_framer #(
      .SYNC_BYTE      (SYNC),
      .TIMEOUT_CYCLES (16'd1000)
   ) dut (
      .clk_i         (clk_i),
      .srst_n_i      (srst_n_i),
      .byte_data_i   (byte_data_i),
      .byte_valid_i  (byte_valid_i),
      .byte_ready_o  (byte_ready_o),
      .cmd_type_o    (cmd_type_o),
      .cmd_data_o    (cmd_data_o),
      .cmd_valid_o   (cmd_valid_o),
      .err_csum_o    (err_csum_o),
      .err_type_o    (err_type_o),
      .err_timeout_o (err_timeout_o),
      .frames_ok_o   (frames_ok_o)
   );

   // kind bits: {cmd, csum error, type error, timeout}
   typedef struct {
      logic [3:0]  kind;
      logic [2:0]  ctype;
      logic [15:0] cdata;
      logic [15:0] frames;
   } ev_t;

   ev_t exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a frame is the four bytes after a SYNC accepted while hunting.
   bit         m_in_frame = 1'b0;
   int         m_n = 0;
   logic [7:0] m_buf[4];
   int         m_idle = 0;
   bit         m_emit = 1'b0;
   int         m_frames = 0;

   always @(posedge clk_i) begin : model
      bit  xfer;
      bit  nxt_emit;
      ev_t ev;
      if (!srst_n_i) begin
         m_in_frame = 1'b0;
         m_n        = 0;
         m_idle     = 0;
         m_emit     = 1'b0;
         m_frames   = 0;
         exp_q.delete();
      end else begin
         xfer     = byte_valid_i && !m_emit;
         nxt_emit = 1'b0;
         if (xfer) begin
            m_idle = 0;
            if (!m_in_frame) begin
               if (byte_data_i == SYNC) begin
                  m_in_frame = 1'b1;
                  m_n        = 0;
               end
            end else begin
               m_buf[m_n] = byte_data_i;
               m_n++;
               if (m_n == 4) begin
                  m_in_frame = 1'b0;
                  ev.ctype   = 3'd0;
                  ev.cdata   = 16'd0;
                  if ((m_buf[0] ^ m_buf[1] ^ m_buf[2]) != m_buf[3]) begin
                     ev.kind = 4'b0100;
                  end else if (m_buf[0] > 8'd5) begin
                     ev.kind = 4'b0010;
                  end else begin
                     ev.kind  = 4'b1000;
                     ev.ctype = m_buf[0][2:0];
                     ev.cdata = {m_buf[1], m_buf[2]};
                     if (m_frames < 65535) m_frames++;
                     nxt_emit = 1'b1;
                  end
                  ev.frames = 16'(m_frames);
                  exp_q.push_back(ev);
               end
            end
         end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == TMO) begin
               ev.kind   = 4'b0001;
               ev.ctype  = 3'd0;
               ev.cdata  = 16'd0;
               ev.frames = 16'(m_frames);
               exp_q.push_back(ev);
               m_in_frame = 1'b0;
               m_idle     = 0;
            end
         end
         m_emit = nxt_emit;
      end
   end

   // Monitor: compares every output event against the scoreboard queue.
   always @(negedge clk_i) begin : monitor
      logic [3:0] got_kind;
      ev_t        ev;
      if (mon_en) begin
         got_kind = {cmd_valid_o, err_csum_o, err_type_o, err_timeout_o};
         check("ready", 32'(byte_ready_o), 32'(!m_emit));
         check("frames_ok", 32'(frames_ok_o), 32'(m_frames));
         if (!cmd_valid_o) check("cmd_zero_when_idle", {13'd0, cmd_type_o, cmd_data_o}, 32'd0);
         if ((got_kind != 4'd0) || (exp_q.size() > 0)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", 32'(got_kind), 32'd0);
            end else begin
               ev = exp_q.pop_front();
               check("event_kind", 32'(got_kind), 32'(ev.kind));
               if (ev.kind[3]) begin
                  check("cmd_type", 32'(cmd_type_o), 32'(ev.ctype));
                  check("cmd_data", 32'(cmd_data_o), 32'(ev.cdata));
                  check("cmd_frames", 32'(frames_ok_o), 32'(ev.frames));
               end
            end
         end
      end
   end

   // Present one byte and hold it until accepted; starts and ends on a negedge.
   task automatic send_byte(input logic [7:0] b);
      int tries = 0;
      bit ok;
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      do begin
         ok = byte_ready_o;
         @(negedge clk_i);
         tries++;
      end while (!ok && (tries < 8));
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL handshake: byte %0h not accepted within %0d cycles", b, tries);
      end
   endtask

   task automatic idle(input int n);
      byte_valid_i = 1'b0;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_frame(input logic [7:0] t, input logic [7:0] h,
                             input logic [7:0] l, input logic [7:0] c);
      send_byte(SYNC);
      send_byte(t);
      send_byte(h);
      send_byte(l);
      send_byte(c);
   endtask

   task automatic do_reset(input int n);
      srst_n_i     = 1'b0;
      byte_valid_i = 1'b0;
      repeat (n) @(negedge clk_i);
      srst_n_i = 1'b1;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] t, h, l, c, g;
      int         k;
      repeat (3) @(negedge clk_i);
      check("rst_ready", 32'(byte_ready_o), 32'd1);
      check("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
      check("rst_errs", {29'd0, err_csum_o, err_type_o, err_timeout_o}, 32'd0);
      check("rst_frames", 32'(frames_ok_o), 32'd0);
      check("rst_cmd", {13'd0, cmd_type_o, cmd_data_o}, 32'd0);
      mon_en   = 1'b1;
      srst_n_i = 1'b1;
      idle(2);

      // Good frame
      send_frame(8'h03, 8'h00, 8'h0A, 8'h09);
      idle(3);
      check("frames_after_good", 32'(frames_ok_o), 32'd1);

      // Leading garbage
      send_byte(8'h11);
      send_byte(8'h22);
      send_frame(8'h00, 8'h00, 8'h00, 8'h00);
      idle(3);

      // Bad checksum then good frame
      send_frame(8'h04, 8'h00, 8'h05, 8'h00);
      send_frame(8'h04, 8'h00, 8'h05, 8'h01);
      idle(3);

      // Bad type
      send_frame(8'h07, 8'h00, 8'h00, 8'h07);
      idle(3);
      check("frames_after_bad_type", 32'(frames_ok_o), 32'd3);

      // SYNC value as frame data
      send_frame(8'h02, SYNC, SYNC, 8'h02);
      idle(2);

      // Timeout, then recovery
      send_byte(SYNC);
      send_byte(8'h03);
      idle(TMO);
      send_frame(8'h01, 8'h12, 8'h34, 8'h27);
      idle(3);
      check("frames_after_timeout", 32'(frames_ok_o), 32'd5);

      // Transfer on the last idle cycle wins over the timeout
      send_byte(SYNC);
      send_byte(8'h03);
      idle(TMO - 1);
      send_byte(8'h00);
      send_byte(8'h0A);
      send_byte(8'h09);
      idle(3);

      // Timeouts in TYPE and CSUM states
      send_byte(SYNC);
      idle(TMO);
      send_byte(SYNC);
      send_byte(8'h05);
      send_byte(8'h01);
      send_byte(8'h02);
      idle(TMO + 3);

      // Reset mid-frame discards silently
      send_byte(SYNC);
      send_byte(8'h03);
      send_byte(8'h00);
      do_reset(2);
      check("frames_after_reset", 32'(frames_ok_o), 32'd0);
      idle(3);
      send_byte(8'h0A);
      send_byte(8'h09);
      idle(3);

      // Back-pressure: next SYNC held valid through EMIT
      send_frame(8'h05, 8'hBE, 8'hEF, 8'h05 ^ 8'hBE ^ 8'hEF);
      check("emit_ready_low", 32'(byte_ready_o), 32'd0);
      send_frame(8'h02, 8'h00, 8'h01, 8'h03);
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 250; i++) begin
         k = int'($urandom_range(0, 2));
         for (int j = 0; j < k; j++) begin
            g = 8'($urandom);
            if (g == SYNC) g = 8'h00;
            send_byte(g);
         end
         if ($urandom_range(0, 39) == 0) begin
            send_byte(SYNC);
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) send_byte(8'($urandom));
            idle(TMO + int'($urandom_range(0, 2)));
         end else begin
            if ($urandom_range(0, 9) < 7) t = 8'($urandom_range(0, 5));
            else                          t = 8'($urandom_range(6, 255));
            h = 8'($urandom);
            l = 8'($urandom);
            c = t ^ h ^ l;
            if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_byte(SYNC);
            send_byte(t);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
            send_byte(h);
            send_byte(l);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
            send_byte(c);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 3)));
         end
      end

      idle(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
